stack_ctrl: RTL
===============

# stack_ctrl

Game sequencer for the block-stacking display. It swings a new block horizontally, drops it on a button press, and decides whether it lands on the tower. It maintains the packed 2-bit-per-layer colour word and the layer count that the renderer draws. It sits between the clock divider's tick and debounced button pulses on one side and the VGA draw logic on the other.

## Interface
Parameters:
- X_MIN, 100, left swing limit (pixel x of block left edge)
- X_MAX, 390, right swing limit
- BASE_X, 260, tower left edge
- SWING_STEP, 5, pixels per tick while swinging
- START_Y, 40, top edge of a newly spawned block
- FALL_STEP, 4, pixels per tick while falling
- P_Y, 400, tower base row
- HEIGHT_RATIO, 20, layer height in pixels
- TOL, 30, max |pos_x − BASE_X| accepted as a landing

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle motion enable (fall clock, synchronised)
- btn_start  in  1  one-cycle start pulse
- btn_drop  in  1  one-cycle drop pulse
- pos_x  out  10  moving block left edge
- drop_y  out  10  moving block top edge
- active  out  1  moving block visible (SWING or DROP)
- colors  out  32  layer i colour in bits [2i+1:2i]; 01 green, 10 red, 11 blue, 00 empty
- height  out  5  layers on tower, 1..16
- lives  out  2  remaining lives
- game_over  out  1  high in OVER
- win  out  1  high in OVER when height reached 16

## Operation
- States: IDLE, SWING, DROP, CHECK, OVER.
- IDLE: btn_start → SWING. Spawn pos_x=X_MIN, dir=right, drop_y=START_Y.
- SWING: on tick, pos_x ±= SWING_STEP.
  - If the step would reach or pass X_MAX (or X_MIN), clamp to the limit and reverse dir.
  - btn_drop → DROP.
- DROP: on tick, compute target = P_Y − height*HEIGHT_RATIO (10-bit, never negative within range).
  - If drop_y + FALL_STEP ≥ target: drop_y = target, go to CHECK.
  - Otherwise drop_y += FALL_STEP.
- CHECK (one cycle): compute diff = |pos_x − BASE_X| unsigned.
  - If diff ≤ TOL (landing): write colour into layer index height and increment height. The colour is height mod 3 mapped 0→01, 1→10, 2→11.
  - If diff > TOL (miss): decrement lives.
  - Next state is OVER if height becomes 16 (win=1) or lives become 0. Otherwise SWING with a fresh spawn.
- OVER: btn_start → IDLE. This reloads colors=32'h1, height=1, and lives to full.
- Precedence:
  - btn_drop and tick in the same SWING cycle: the drop wins and pos_x holds.
  - btn_drop outside SWING and btn_start outside IDLE/OVER are ignored.
  - tick outside SWING/DROP is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE, pos_x=X_MIN, drop_y=START_Y, active=0, colors=32'h0000_0001, height=1, lives=full, game_over=0, win=0.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously. Operation resumes on the first clk edge after rst rises.
- Latencies:
  - btn_drop → active DROP on the next edge.
  - Landing tick → CHECK on the next edge.
  - CHECK → colors/height updated and the new state on the following edge.
- Motion occurs only on cycles with tick=1. Position arithmetic is 10-bit with clamping, so there is no wrap-around.

## Configuration
- STACK_CTRL_LIVES_EN defined: lives resets to 3, and each miss decrements it.
- Not defined: lives is held at 1 and the first miss goes to OVER. The lives port is still present.

## Structure
- Package stack_pkg holds:
  - the state enum;
  - colour codes GREEN=01, RED=10, BLUE=11;
  - geometry defaults;
  - MAX_LAYERS=16.
- One sub-module, swing_counter. It is a bounded up/down position counter with step, limits, load and enable. It is used for pos_x.
- The FSM, fall logic and colour packing stay in stack_ctrl.

## Test plan
- Reset, then btn_start, then 4 ticks → pos_x=120, active=1.
- 58 ticks from spawn → pos_x clamps at 390, dir reverses, and the next tick gives pos_x=385.
- Drop at pos_x=260 with height=1 → drop_y stops at 380, then height=2 and colors[3:2]=10.
- Drop at pos_x=100 (diff 160) with STACK_CTRL_LIVES_EN → lives 3→2, height unchanged, respawn at X_MIN. Without the macro → OVER, game_over=1.
- 15 consecutive landings → height=16, win=1, game_over=1. Then btn_start → IDLE with colors=32'h1.
- btn_drop and tick in the same cycle → pos_x unchanged and DROP entered. Asserting rst low during DROP → all outputs return to reset values immediately.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the block-stacking game sequencer.
package stack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWING,
        ST_DROP,
        ST_CHECK,
        ST_OVER
    } state_t;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] GREEN = 2'b01;
    localparam logic [1:0] RED   = 2'b10;
    localparam logic [1:0] BLUE  = 2'b11;

    localparam int POS_W          = 10;
    localparam int MAX_LAYERS     = 16;
    localparam int DEF_X_MIN      = 100;
    localparam int DEF_X_MAX      = 390;
    localparam int DEF_BASE_X     = 260;
    localparam int DEF_SWING_STEP = 5;
    localparam int DEF_START_Y    = 40;
    localparam int DEF_FALL_STEP  = 4;
    localparam int DEF_P_Y        = 400;
    localparam int DEF_HEIGHT_RAT = 20;
    localparam int DEF_TOL        = 30;

    // Layers cycle green, red, blue by index.
    function automatic logic [1:0] layerColour(input logic [4:0] layerIdx);
        logic [4:0] phase;
        phase = layerIdx % 5'd3;
        case (phase)
            5'd0:    layerColour = GREEN;
            5'd1:    layerColour = RED;
            default: layerColour = BLUE;
        endcase
    endfunction

endpackage

// File: rtl/stack_ctrl_swing_counter.sv
// Bounded up/down position counter: steps between two limits and bounces off them.
module swing_counter #(
    parameter int W       = 10,
    parameter int MIN_POS = 100,
    parameter int MAX_POS = 390,
    parameter int STEP    = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    output logic [W-1:0] pos_o
);

    localparam logic [W-1:0] LO      = W'(MIN_POS);
    localparam logic [W-1:0] HI      = W'(MAX_POS);
    localparam logic [W-1:0] STEP_W  = W'(STEP);
    localparam logic [W-1:0] LO_TURN = W'(MIN_POS + STEP);
    localparam logic [W-1:0] HI_TURN = W'(MAX_POS - STEP);

    logic [W-1:0] pos_q, pos_d;
    logic         up_q, up_d;

    // Compare against pre-offset limits so the step never overflows or underflows.
    always_comb begin
        pos_d = pos_q;
        up_d  = up_q;
        if (load_i) begin
            pos_d = LO;
            up_d  = 1'b1;
        end else if (en_i) begin
            if (up_q) begin
                if (pos_q >= HI_TURN) begin
                    pos_d = HI;
                    up_d  = 1'b0;
                end else begin
                    pos_d = pos_q + STEP_W;
                end
            end else begin
                if (pos_q <= LO_TURN) begin
                    pos_d = LO;
                    up_d  = 1'b1;
                end else begin
                    pos_d = pos_q - STEP_W;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q <= LO;
            up_q  <= 1'b1;
        end else begin
            pos_q <= pos_d;
            up_q  <= up_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/stack_ctrl.sv
// Block-stacking game sequencer: swing, drop, landing check and tower bookkeeping.
// Define STACK_CTRL_LIVES_EN for three lives; otherwise the first miss ends the game.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int X_MIN        = DEF_X_MIN,
    parameter int X_MAX        = DEF_X_MAX,
    parameter int BASE_X       = DEF_BASE_X,
    parameter int SWING_STEP   = DEF_SWING_STEP,
    parameter int START_Y      = DEF_START_Y,
    parameter int FALL_STEP    = DEF_FALL_STEP,
    parameter int P_Y          = DEF_P_Y,
    parameter int HEIGHT_RATIO = DEF_HEIGHT_RAT,
    parameter int TOL          = DEF_TOL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        btn_drop,
    output logic [9:0]  pos_x,
    output logic [9:0]  drop_y,
    output logic        active,
    output logic [31:0] colors,
    output logic [4:0]  height,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        win
);

`ifdef STACK_CTRL_LIVES_EN
    localparam logic [1:0] LIVES_FULL = 2'd3;
`else
    localparam logic [1:0] LIVES_FULL = 2'd1;
`endif

    localparam logic [9:0]  START_Y_W = 10'(START_Y);
    localparam logic [31:0] COLORS_INIT = 32'h0000_0001;

    state_t      state_q;
    logic [9:0]  dropY_q;
    logic [31:0] colors_q;
    logic [4:0]  height_q;
    logic [1:0]  lives_q;
    logic        active_q;
    logic        gameOver_q;
    logic        win_q;

    logic [9:0]  swingPos;
    logic [9:0]  fallTarget;
    logic [9:0]  fallNext;
    logic [9:0]  landDiff;
    logic        landHit;
    logic [4:0]  heightInc;
    logic        gameWon;
    logic        lastLife;
    logic        checkEnds;
    logic [31:0] landColors;
    logic        respawn;
    logic        swingEn;

    always_comb begin
        fallTarget = 10'(P_Y - 32'(height_q) * HEIGHT_RATIO);
        fallNext   = dropY_q + 10'(FALL_STEP);
        landDiff   = (swingPos >= 10'(BASE_X)) ? (swingPos - 10'(BASE_X))
                                               : (10'(BASE_X) - swingPos);
        landHit    = (landDiff <= 10'(TOL));
        heightInc  = height_q + 5'd1;
        gameWon    = (heightInc == 5'(MAX_LAYERS));
        // Without the lives feature the counter sits at one, so any miss is the last.
        lastLife   = (lives_q <= 2'd1);
        checkEnds  = landHit ? gameWon : lastLife;
        landColors = colors_q | (32'(layerColour(height_q)) << {height_q[3:0], 1'b0});
        respawn    = ((state_q == ST_IDLE) && btn_start)
                  || ((state_q == ST_CHECK) && !checkEnds)
                  || ((state_q == ST_OVER) && btn_start);
        // A drop request freezes the block where it is, even if a tick arrives too.
        swingEn    = (state_q == ST_SWING) && tick && !btn_drop;
    end

    swing_counter #(
        .W       (10),
        .MIN_POS (X_MIN),
        .MAX_POS (X_MAX),
        .STEP    (SWING_STEP)
    ) u_swing (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (respawn),
        .en_i   (swingEn),
        .pos_o  (swingPos)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dropY_q    <= START_Y_W;
            colors_q   <= COLORS_INIT;
            height_q   <= 5'd1;
            lives_q    <= LIVES_FULL;
            active_q   <= 1'b0;
            gameOver_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_start) begin
                        state_q  <= ST_SWING;
                        active_q <= 1'b1;
                        dropY_q  <= START_Y_W;
                    end
                end
                ST_SWING: begin
                    if (btn_drop) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (tick) begin
                        if (fallNext >= fallTarget) begin
                            dropY_q  <= fallTarget;
                            state_q  <= ST_CHECK;
                            active_q <= 1'b0;
                        end else begin
                            dropY_q <= fallNext;
                        end
                    end
                end
                ST_CHECK: begin
                    if (landHit) begin
                        colors_q <= landColors;
                        height_q <= heightInc;
                    end
`ifdef STACK_CTRL_LIVES_EN
                    else begin
                        lives_q <= lives_q - 2'd1;
                    end
`endif
                    if (checkEnds) begin
                        state_q    <= ST_OVER;
                        gameOver_q <= 1'b1;
                        win_q      <= landHit;
                    end else begin
                        state_q  <= ST_SWING;
                        active_q <= 1'b1;
                        dropY_q  <= START_Y_W;
                    end
                end
                ST_OVER: begin
                    if (btn_start) begin
                        state_q    <= ST_IDLE;
                        gameOver_q <= 1'b0;
                        win_q      <= 1'b0;
                        colors_q   <= COLORS_INIT;
                        height_q   <= 5'd1;
                        lives_q    <= LIVES_FULL;
                        dropY_q    <= START_Y_W;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pos_x     = swingPos;
    assign drop_y    = dropY_q;
    assign active    = active_q;
    assign colors    = colors_q;
    assign height    = height_q;
    assign lives     = lives_q;
    assign game_over = gameOver_q;
    assign win       = win_q;

endmodule
